store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- Buffers stores between the pipeline MEM stage and the data memory write port.
- Captures each store as memwrite/dataadr/writedata, converts its size into byte-enables plus lane-replicated data, and queues it in a small FIFO.
- Drains the FIFO to data memory under a ready handshake.
- Stalls the pipeline when full, and flags loads that hit a word still queued.

Parameters:
- DEPTH, 4: number of FIFO entries; power of two, minimum 2.
- AW, 32: byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- memwrite  in  2  store size from MEM stage: 00 none, 01 byte, 10 halfword, 11 word.
- dataadr  in  AW  store byte address.
- writedata  in  32  store data, right-aligned.
- ld_req  in  1  MEM-stage load this cycle.
- ld_adr  in  AW  load byte address.
- dm_ready  in  1  data memory accepts the presented write this cycle.
- dm_we  out  1  write valid to data memory.
- dm_adr  out  AW  word-aligned write address ({adr[AW-1:2],2'b00}).
- dm_be  out  4  byte enables; bit i covers data byte i.
- dm_wdata  out  32  lane-replicated write data.
- sb_full  out  1  stall request to pipeline.
- ld_conflict  out  1  load must stall (see Behaviour).
- misalign_err  out  1  one-cycle pulse: a misaligned store was dropped.

Behaviour:
- Reset values: count, head and tail pointers = 0; all entries invalid; dm_we = 0, dm_adr = 0, dm_be = 0, dm_wdata = 0, sb_full = 0, misalign_err = 0, ld_conflict = 0.
- Reset is asynchronous. Asserting it mid-drain discards every queued store immediately, with no partial completion.
- Formatting (memwrite != 00):
  - Byte: be = 4'b0001 << adr[1:0]; data = {4{wd[7:0]}}.
  - Half: adr[0] must be 0; be = adr[1] ? 1100 : 0011; data = {2{wd[15:0]}}.
  - Word: adr[1:0] must be 00; be = 1111; data = wd.
- Misaligned store: not enqueued. misalign_err pulses high on the following cycle (registered).
- Enqueue: a valid, aligned store is written at tail when count < DEPTH; tail advances and wraps modulo DEPTH.
- Enqueue while full: the store is ignored. The pipeline holds it because sb_full = 1.
- sb_full = (count == DEPTH). It is decoded from registered count only, so there is no combinational path from dm_ready.
- Drain:
  - dm_we = (count != 0).
  - dm_adr, dm_be, dm_wdata come straight from the head entry registers.
  - A dequeue occurs when dm_we && dm_ready; head advances with wrap.
  - Outputs are stable while dm_we = 1 and dm_ready = 0.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance. Allowed only when count < DEPTH.
- Latency: a store accepted in cycle N is presented on dm_* in cycle N+1 at the earliest (empty buffer).
- Ordering: strict FIFO; no write merging or reordering.
- ld_conflict: combinational. Asserted when ld_req = 1 and any valid entry matches ld_adr[AW-1:2].

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: adds outputs ld_fwd_valid (1) and ld_fwd_data (32).
  - If the youngest matching entry has be = 1111, assert ld_fwd_valid, drive ld_fwd_data from that entry, and hold ld_conflict = 0.
  - If a match exists but be != 1111, assert ld_conflict instead.
  - Youngest is found by scanning from tail-1 back toward head.
- Undefined: no forwarding ports; every address match raises ld_conflict.

Decomposition:
- Package mips_mem_pkg holds:
  - typedef enum logic [1:0] mem_size_t {MS_NONE, MS_BYTE, MS_HALF, MS_WORD};
  - typedef struct packed sb_entry_t {adr, be, data};
  - localparam BE_FULL = 4'b1111.
- One natural sub-module: sb_store_format, the combinational size/alignment formatter returning be, data and a misaligned flag.
- The FIFO and forwarding logic stay in store_write_buffer.

Test Plan:
- Reset held low for 2 cycles with dm_ready = 1 → all outputs 0, and they stay 0 after release with no stores.
- Word store: memwrite = 11, dataadr = 84, writedata = 0x41800888, dm_ready = 1 → next cycle dm_we = 1, dm_adr = 0x54, dm_be = 1111, dm_wdata = 0x41800888; one cycle later dm_we = 0.
- Byte store: memwrite = 01, dataadr = 0x57, writedata = 0xAB → dm_be = 1000, dm_wdata = 0xABABABAB. Half store at 0x56 → dm_be = 1100, data = {2{wd[15:0]}}.
- Fill: 5 word stores with dm_ready = 0 → sb_full = 1 after the 4th; the 5th is ignored. Raise dm_ready → 4 writes drain in order, 1 per cycle.
- Misaligned word at 0x55 → misalign_err pulses one cycle; count unchanged; no dm_we.
- Load conflict: queue a byte store to 0x80, hold dm_ready = 0, issue ld_req with ld_adr = 0x83 → ld_conflict = 1.
  - With STORE_FWD_EN, a queued word store 0x12345678 at 0x80 instead gives ld_fwd_valid = 1 and ld_fwd_data = 0x12345678.
- Reset mid-drain with 3 entries queued → dm_we drops to 0 asynchronously; after release the buffer is empty.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer.
//   mem_size_t : MEM-stage store size encoding (memwrite)
//   sb_entry_t : one queued store (word address, byte enables, lane data)
//   BE_FULL    : all four byte lanes enabled
package mips_mem_pkg;

    typedef enum logic [1:0] {MS_NONE, MS_BYTE, MS_HALF, MS_WORD} mem_size_t;

    // Entries hold addresses at the widest supported AW; narrower builds zero-extend.
    localparam int         SB_ADR_W = 32;
    localparam logic [3:0] BE_FULL  = 4'b1111;

    typedef struct packed {
        logic [SB_ADR_W-1:0] adr;
        logic [3:0]          be;
        logic [31:0]         data;
    } sb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Bus bundle between the MEM stage / data memory and the store write buffer.
//   slave  : the buffer's view (store + load probe + dm_ready in; dm_* and status out)
//   master : the surrounding pipeline / memory view
// When STORE_FWD_EN is defined the bundle also carries ld_fwd_valid / ld_fwd_data.
interface store_write_buffer_if #(parameter int AW = 32);
    logic [1:0]    memwrite;
    logic [AW-1:0] dataadr;
    logic [31:0]   writedata;
    logic          ld_req;
    logic [AW-1:0] ld_adr;
    logic          dm_ready;
    logic          dm_we;
    logic [AW-1:0] dm_adr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wdata;
    logic          sb_full;
    logic          ld_conflict;
    logic          misalign_err;
`ifdef STORE_FWD_EN
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;
`endif

    modport slave (
        input  memwrite, dataadr, writedata, ld_req, ld_adr, dm_ready,
`ifdef STORE_FWD_EN
        output ld_fwd_valid, ld_fwd_data,
`endif
        output dm_we, dm_adr, dm_be, dm_wdata, sb_full, ld_conflict, misalign_err
    );

    modport master (
        output memwrite, dataadr, writedata, ld_req, ld_adr, dm_ready,
`ifdef STORE_FWD_EN
        input  ld_fwd_valid, ld_fwd_data,
`endif
        input  dm_we, dm_adr, dm_be, dm_wdata, sb_full, ld_conflict, misalign_err
    );
endinterface

// File: rtl/store_write_buffer_format.sv
// sb_store_format: combinational store formatter.
//   size_i     : store size (MS_NONE gives be = 0)
//   adr_lo_i   : byte offset within the word
//   wd_i       : right-aligned store data
//   be_o       : byte enables, bit i = data byte i
//   data_o     : store data replicated across all lanes it could land in
//   misalign_o : half not on a 2-byte boundary, or word not on a 4-byte boundary
module sb_store_format
    import mips_mem_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [1:0]  adr_lo_i,
    input  logic [31:0] wd_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);
    always_comb begin
        be_o       = 4'b0000;
        data_o     = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            MS_BYTE: begin
                be_o   = 4'b0001 << adr_lo_i;
                data_o = {4{wd_i[7:0]}};
            end
            MS_HALF: begin
                misalign_o = adr_lo_i[0];
                be_o       = adr_lo_i[1] ? 4'b1100 : 4'b0011;
                data_o     = {2{wd_i[15:0]}};
            end
            MS_WORD: begin
                misalign_o = |adr_lo_i;
                be_o       = BE_FULL;
                data_o     = wd_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO of formatted stores between MEM stage and data memory.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   sb    : store_write_buffer_if.slave
//           in : memwrite, dataadr, writedata, ld_req, ld_adr, dm_ready
//           out: dm_we, dm_adr, dm_be, dm_wdata, sb_full, ld_conflict, misalign_err
// Optional macro STORE_FWD_EN: forward full-word stores to matching loads
// through ld_fwd_valid / ld_fwd_data instead of raising ld_conflict.
module store_write_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  sb
);
    localparam int           PW       = $clog2(DEPTH);
    localparam logic [PW:0]  CNT_FULL = (PW+1)'(DEPTH);

    sb_entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PW:0]        cnt_q, cnt_d;
    logic               mis_q, mis_d;

    logic [3:0]         fmt_be;
    logic [31:0]        fmt_data;
    logic               fmt_mis;
    logic               store_v, full, enq, deq;
    sb_entry_t          new_ent;
    logic [AW-1:0]      ld_word;
    logic [DEPTH-1:0]   match;

    sb_store_format u_fmt (
        .size_i     (mem_size_t'(sb.memwrite)),
        .adr_lo_i   (sb.dataadr[1:0]),
        .wd_i       (sb.writedata),
        .be_o       (fmt_be),
        .data_o     (fmt_data),
        .misalign_o (fmt_mis)
    );

    always_comb begin
        store_v = sb.memwrite != 2'b00;
        full    = cnt_q == CNT_FULL;
        // full blocks enqueue, so enqueue+dequeue only overlap below DEPTH
        enq     = store_v && !fmt_mis && !full;
        deq     = (cnt_q != '0) && sb.dm_ready;
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        cnt_d   = cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
        mis_d   = store_v && fmt_mis;
        vld_d   = vld_q;
        if (deq) vld_d[head_q] = 1'b0;
        if (enq) vld_d[tail_q] = 1'b1;
        new_ent.adr  = SB_ADR_W'({sb.dataadr[AW-1:2], 2'b00});
        new_ent.be   = fmt_be;
        new_ent.data = fmt_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
            mis_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            mis_q  <= mis_d;
            if (enq) ent_q[tail_q] <= new_ent;
        end
    end

    // Drain side: head entry drives the memory port directly
    assign sb.dm_we        = cnt_q != '0;
    assign sb.dm_adr       = ent_q[head_q].adr[AW-1:0];
    assign sb.dm_be        = ent_q[head_q].be;
    assign sb.dm_wdata     = ent_q[head_q].data;
    assign sb.sb_full      = full;
    assign sb.misalign_err = mis_q;

    // Word-granular load probe against every live entry
    assign ld_word = sb.ld_adr & ~AW'(3);
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            match[i] = vld_q[i] && (ent_q[i].adr[AW-1:0] == ld_word);
    end

`ifdef STORE_FWD_EN
    logic          fnd;
    logic [3:0]    fnd_be;
    logic [31:0]   fnd_data;
    logic [PW-1:0] idx;

    // Walk from the youngest entry (tail-1) toward head; first hit wins.
    always_comb begin
        fnd      = 1'b0;
        fnd_be   = 4'b0000;
        fnd_data = 32'h0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_q - PW'(k + 1);
            if (!fnd && match[idx]) begin
                fnd      = 1'b1;
                fnd_be   = ent_q[idx].be;
                fnd_data = ent_q[idx].data;
            end
        end
    end

    assign sb.ld_fwd_valid = sb.ld_req && fnd && (fnd_be == BE_FULL);
    assign sb.ld_fwd_data  = sb.ld_fwd_valid ? fnd_data : 32'h0;
    assign sb.ld_conflict  = sb.ld_req && fnd && (fnd_be != BE_FULL);
`else
    assign sb.ld_conflict  = sb.ld_req && (|match);
`endif

endmodule
